// File: rtl/regfile.sv
// MIPS general-purpose register file: two combinational read ports, one write port, $0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic              hit1_s;
  logic              hit2_s;
  logic [DATA_W-1:0] rdata1_s;
  logic [DATA_W-1:0] rdata2_s;

  // Read-port priority: reset, disable and $0 force zero ahead of forwarding and storage.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic              rst_i,
    input logic              en_i,
    input logic [ADDR_W-1:0] addr_i,
    input logic              hit_i,
    input logic [DATA_W-1:0] fwd_i,
    input logic [DATA_W-1:0] stored_i
  );
    logic [DATA_W-1:0] val;
    val = ZERO_DATA;
    if (rst_i || !en_i || (addr_i == ZERO_ADDR)) begin
      val = ZERO_DATA;
    end else if (hit_i) begin
      val = fwd_i;
    end else begin
      val = stored_i;
    end
    return val;
  endfunction

`ifdef REGFILE_BYPASS_EN
  assign hit1_s = we && (raddr1 == waddr);
  assign hit2_s = we && (raddr2 == waddr);
`else
  assign hit1_s = 1'b0;
  assign hit2_s = 1'b0;
`endif

  // Register array update: reset clears everything and beats a concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= ZERO_DATA;
      end
    end else if (we && (waddr != ZERO_ADDR)) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Independent combinational read ports.
  always_comb begin
    rdata1_s = ZERO_DATA;
    rdata2_s = ZERO_DATA;
    rdata1_s = read_mux(rst, re1, raddr1, hit1_s, wdata, regs_r[raddr1]);
    rdata2_s = read_mux(rst, re2, raddr2, hit2_s, wdata, regs_r[raddr2]);
  end

  assign rdata1 = rdata1_s;
  assign rdata2 = rdata2_s;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: array-based reference model checked every cycle, plus directed literal checks.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [32];
  bit          model_valid = 1'b0;

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expect_read(input logic en, input logic [4:0] ra);
    if (rst || !en || ra == 5'd0) return 32'd0;
    if (BYPASS && we && ra == waddr) return wdata;
    return model[ra];
  endfunction

  // Reference state: what the architectural registers hold after each edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] <= 32'd0;
      model_valid <= 1'b1;
    end else if (we && waddr != 5'd0) begin
      model[waddr] <= wdata;
    end
  end

  // Continuous comparison of both ports mid-cycle.
  always @(negedge clk) begin
    if (rst || model_valid) begin
      check("model_port1", rdata1, expect_read(re1, raddr1));
      check("model_port2", rdata2, expect_read(re2, raddr2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'd0;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd17;

    // reset state
    tick();
    @(negedge clk);
    check("rst_port1", rdata1, 32'd0);
    check("rst_port2", rdata2, 32'd0);
    rst = 1'b0;

    // preload then reset clear
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr1 = 5'd5;
    tick();
    we = 1'b0;
    @(negedge clk);
    check("preload_r5", rdata1, 32'hDEAD_BEEF);
    rst = 1'b1; raddr2 = 5'd5;
    tick();
    raddr1 = 5'd31;
    @(negedge clk);
    check("during_rst_p1", rdata1, 32'd0);
    check("during_rst_p2", rdata2, 32'd0);
    rst = 1'b0; raddr1 = 5'd5;
    tick();
    @(negedge clk);
    check("after_rst_r5", rdata1, 32'd0);

    // basic write/read
    we = 1'b1; waddr = 5'd3; wdata = 32'h1234_5678;
    tick();
    we = 1'b0; raddr1 = 5'd3; raddr2 = 5'd3;
    @(negedge clk);
    check("basic_p1", rdata1, 32'h1234_5678);
    check("basic_p2", rdata2, 32'h1234_5678);
    re2 = 1'b0;
    tick();
    @(negedge clk);
    check("re2_off", rdata2, 32'd0);
    re2 = 1'b1;

    // $0 hardwired
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0;
    @(negedge clk);
    check("zero_same_cycle", rdata1, 32'd0);
    tick();
    we = 1'b0;
    @(negedge clk);
    check("zero_next_cycle", rdata1, 32'd0);

    // same-cycle bypass
    we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0001;
    tick();
    wdata = 32'h0000_00AA; raddr1 = 5'd7;
    @(negedge clk);
    check("bypass_before_edge", rdata1, BYPASS ? 32'h0000_00AA : 32'h0000_0001);
    tick();
    we = 1'b0;
    @(negedge clk);
    check("bypass_after_edge", rdata1, 32'h0000_00AA);

    // reset vs write collision
    rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h5555_5555;
    tick();
    rst = 1'b0; we = 1'b0; raddr1 = 5'd9;
    @(negedge clk);
    check("rst_beats_write", rdata1, 32'd0);

    // back-to-back writes and bubble
    we = 1'b1; waddr = 5'd4; wdata = 32'h0000_000A; raddr1 = 5'd4;
    tick();
    wdata = 32'h0000_000B;
    tick();
    @(negedge clk);
    check("b2b_after_edge2", rdata1, 32'h0000_000B);
    we = 1'b0; waddr = 5'd0; wdata = 32'd0;
    tick();
    @(negedge clk);
    check("b2b_after_bubble", rdata1, 32'h0000_000B);

    // every other register still zero
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      @(negedge clk);
      check("scan_p1", rdata1, (i == 4) ? 32'h0000_000B : 32'd0);
      check("scan_p2", rdata2, ((31 - i) == 4) ? 32'h0000_000B : 32'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
